// File: rtl/pwm_timer_pkg.sv
// Shared definitions for the PWM/timer block: ctrl bit layout, channel FSM encoding
// and per-channel register offsets used by both the register file and the core.
package pwm_timer_pkg;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_MODE   = 1;
  localparam int unsigned CTRL_CONT   = 2;
  localparam int unsigned CTRL_IRQ_EN = 3;
  localparam int unsigned CTRL_POL    = 4;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_PERIOD  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;
  localparam logic [1:0] REG_DC      = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic pol;
    logic irq_en;
    logic cont;
    logic mode;
    logic en;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [4:0] raw);
    ctrl_t c;
    c.en     = raw[CTRL_EN];
    c.mode   = raw[CTRL_MODE];
    c.cont   = raw[CTRL_CONT];
    c.irq_en = raw[CTRL_IRQ_EN];
    c.pol    = raw[CTRL_POL];
    return c;
  endfunction

endpackage

// File: rtl/pwm_channel_core_if.sv
// Per-channel connection between the register file (master) and the counting core (slave).
interface pwm_channel_core_if #(
  parameter int unsigned DW = 16
);
  logic [DW-1:0] i_ctrl;
  logic [DW-1:0] i_period;
  logic [DW-1:0] i_divisor;
  logic [DW-1:0] i_dc;
  logic          i_irq_clr;
  logic          o_pwm;
  logic          o_irq;
  logic [DW-1:0] o_cnt;
  logic          o_busy;

  modport master (
    output i_ctrl, i_period, i_divisor, i_dc, i_irq_clr,
    input  o_pwm, o_irq, o_cnt, o_busy
  );

  modport slave (
    input  i_ctrl, i_period, i_divisor, i_dc, i_irq_clr,
    output o_pwm, o_irq, o_cnt, o_busy
  );
endinterface

// File: rtl/pwm_prescaler.sv
// Clock prescaler: emits a one-clock tick every max(divisor,1) clocks while running.
module pwm_prescaler #(
  parameter int unsigned DW = 16
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst,
  input  logic [DW-1:0] i_divisor,
  input  logic          i_run,
  output logic          o_tick
);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [DW-1:0] term;

  // Divisor is read live; >= keeps the period bounded if it shrinks below div_cnt.
  assign term   = (i_divisor == '0) ? '0 : i_divisor - DW'(1);
  assign o_tick = i_run && (div_cnt_q >= term);

  always_comb begin
    div_cnt_d = div_cnt_q + DW'(1);
    if (!i_run || o_tick) begin
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_channel_core.sv
// Counting engine for one PWM/timer channel: IDLE/RUN/DONE FSM, shadowed period/duty,
// registered PWM output and sticky wrap interrupt.
module pwm_channel_core
  import pwm_timer_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input logic               i_wb_clk,
  input logic               i_wb_rst,
  pwm_channel_core_if.slave bus
);

  state_e        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] period_sh_q, period_sh_d;
  logic [DW-1:0] dc_sh_q, dc_sh_d;
  logic          pwm_q, pwm_d;
  logic          irq_q, irq_d;
  logic          tick;
  logic          wrap;
  logic          act;
  logic          run;
  ctrl_t         ctrl;
  logic          unused_ctrl_bits;

  assign ctrl             = decode_ctrl(bus.i_ctrl[4:0]);
  assign unused_ctrl_bits = ^bus.i_ctrl[DW-1:5];

  // Prescaler only runs while staying in RUN, so it clears on the disabling edge.
  assign run = (state_q == ST_RUN) && ctrl.en;

  pwm_prescaler #(
    .DW (DW)
  ) u_prescaler (
    .i_wb_clk  (i_wb_clk),
    .i_wb_rst  (i_wb_rst),
    .i_divisor (bus.i_divisor),
    .i_run     (run),
    .o_tick    (tick)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_sh_d = period_sh_q;
    dc_sh_d     = dc_sh_q;
    wrap        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ctrl.en) begin
          state_d     = ST_RUN;
          cnt_d       = '0;
          period_sh_d = bus.i_period;
          dc_sh_d     = bus.i_dc;
        end
      end
      ST_RUN: begin
        if (!ctrl.en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (tick && (period_sh_q != '0)) begin
          if (cnt_q == period_sh_q - DW'(1)) begin
            wrap        = 1'b1;
            cnt_d       = '0;
            period_sh_d = bus.i_period;
            dc_sh_d     = bus.i_dc;
            if (!ctrl.cont) begin
              state_d = ST_DONE;
            end
          end else begin
            cnt_d = cnt_q + DW'(1);
          end
        end
      end
      ST_DONE: begin
        if (!ctrl.en) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    irq_d = irq_q;
    // Set wins over a simultaneous clear.
    if (wrap && ctrl.irq_en) begin
      irq_d = 1'b1;
    end else if (bus.i_irq_clr) begin
      irq_d = 1'b0;
    end
  end

  assign act   = ctrl.mode && (state_q == ST_RUN) && (cnt_q < dc_sh_q);
  assign pwm_d = act ^ ctrl.pol;

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      period_sh_q <= '0;
      dc_sh_q     <= '0;
      pwm_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_sh_q <= period_sh_d;
      dc_sh_q     <= dc_sh_d;
      pwm_q       <= pwm_d;
      irq_q       <= irq_d;
    end
  end

  assign bus.o_pwm  = pwm_q;
  assign bus.o_irq  = irq_q;
  assign bus.o_cnt  = cnt_q;
  assign bus.o_busy = (state_q == ST_RUN);

endmodule

// File: tb/tb_pwm_channel_core.sv
// Directed bench for pwm_channel_core: expectations are queued as stimulus is driven
// and popped/compared at the falling edge after the DUT updates.
module tb_pwm_channel_core;

  localparam int SEL_PWM  = 0;
  localparam int SEL_IRQ  = 1;
  localparam int SEL_CNT  = 2;
  localparam int SEL_BUSY = 3;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  pwm_channel_core_if #(.DW(16)) bus ();

  pwm_channel_core #(
    .DW (16)
  ) dut (
    .i_wb_clk (clk),
    .i_wb_rst (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      SEL_PWM:  return {15'd0, bus.o_pwm};
      SEL_IRQ:  return {15'd0, bus.o_irq};
      SEL_CNT:  return bus.o_cnt;
      default:  return {15'd0, bus.o_busy};
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic compare_all();
    exp_t        e;
    logic [15:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic [15:0] c, input logic [15:0] p, input logic [15:0] d,
                       input logic [15:0] dc);
    bus.i_ctrl    = c;
    bus.i_period  = p;
    bus.i_divisor = d;
    bus.i_dc      = dc;
  endtask

  // Leave RUN with EN low; output settles at POL one clock later.
  task automatic go_idle(input logic pol);
    bus.i_ctrl = {11'd0, pol, 4'd0};
    push("idle_busy", SEL_BUSY, 16'd0);
    push("idle_cnt", SEL_CNT, 16'd0);
    cyc();
    push("idle_pwm", SEL_PWM, {15'd0, pol});
    push("idle_busy2", SEL_BUSY, 16'd0);
    cyc();
  endtask

  initial begin
    logic [15:0] p;
    int          dcv;
    int          irqv;
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.i_irq_clr = 1'b0;
    drive(16'h0, 16'd0, 16'd0, 16'd0);
    @(negedge clk);
    @(negedge clk);
    push("rst_pwm", SEL_PWM, 16'd0);
    push("rst_irq", SEL_IRQ, 16'd0);
    push("rst_cnt", SEL_CNT, 16'd0);
    push("rst_busy", SEL_BUSY, 16'd0);
    compare_all();
    rst = 1'b0;

    // PWM basic: 1 high, 3 low.
    drive(16'h07, 16'd4, 16'd1, 16'd1);
    push("basic_e0_busy", SEL_BUSY, 16'd1);
    push("basic_e0_cnt", SEL_CNT, 16'd0);
    push("basic_e0_pwm", SEL_PWM, 16'd0);
    cyc();
    for (int k = 1; k <= 12; k++) begin
      push("basic_cnt", SEL_CNT, 16'(k % 4));
      push("basic_pwm", SEL_PWM, 16'(((k - 1) % 4) < 1));
      push("basic_irq", SEL_IRQ, 16'd0);
      cyc();
    end
    go_idle(1'b0);

    // Prescaled PWM: 6 high, 6 low, counter advances every 3 clocks.
    drive(16'h07, 16'd4, 16'd3, 16'd2);
    push("presc_e0_busy", SEL_BUSY, 16'd1);
    push("presc_e0_cnt", SEL_CNT, 16'd0);
    cyc();
    for (int k = 1; k <= 24; k++) begin
      push("presc_cnt", SEL_CNT, 16'((k / 3) % 4));
      push("presc_pwm", SEL_PWM, 16'((((k - 1) / 3) % 4) < 2));
      cyc();
    end
    go_idle(1'b0);

    // Timer one-shot: irq 10 clocks after enable, then DONE with EN still high.
    drive(16'h09, 16'd5, 16'd2, 16'd0);
    push("timer_e0_busy", SEL_BUSY, 16'd1);
    push("timer_e0_cnt", SEL_CNT, 16'd0);
    cyc();
    for (int k = 1; k <= 9; k++) begin
      push("timer_cnt", SEL_CNT, 16'(k / 2));
      push("timer_irq", SEL_IRQ, 16'd0);
      push("timer_busy", SEL_BUSY, 16'd1);
      push("timer_pwm", SEL_PWM, 16'd0);
      cyc();
    end
    push("timer_wrap_irq", SEL_IRQ, 16'd1);
    push("timer_wrap_busy", SEL_BUSY, 16'd0);
    push("timer_wrap_cnt", SEL_CNT, 16'd0);
    cyc();
    for (int k = 0; k < 4; k++) begin
      push("timer_done_busy", SEL_BUSY, 16'd0);
      push("timer_done_irq", SEL_IRQ, 16'd1);
      push("timer_done_cnt", SEL_CNT, 16'd0);
      cyc();
    end
    bus.i_irq_clr = 1'b1;
    push("timer_clr_irq", SEL_IRQ, 16'd0);
    cyc();
    bus.i_irq_clr = 1'b0;
    bus.i_ctrl    = 16'h0;
    push("timer_off_busy", SEL_BUSY, 16'd0);
    cyc();

    // Boundary levels, both polarities.
    for (int pol = 0; pol < 2; pol++) begin
      p = 16'(pol << 4);
      drive(16'h07 | p, 16'd4, 16'd1, 16'd0);
      push("dc0_e0_busy", SEL_BUSY, 16'd1);
      cyc();
      for (int k = 1; k <= 8; k++) begin
        push("dc0_pwm", SEL_PWM, 16'(pol));
        cyc();
      end
      go_idle(pol[0]);
      drive(16'h07 | p, 16'd4, 16'd1, 16'd7);
      push("dcfull_e0_busy", SEL_BUSY, 16'd1);
      cyc();
      for (int k = 1; k <= 8; k++) begin
        push("dcfull_pwm", SEL_PWM, 16'(pol == 0));
        cyc();
      end
      go_idle(pol[0]);
      drive(16'h0F | p, 16'd0, 16'd1, 16'd2);
      push("per0_e0_busy", SEL_BUSY, 16'd1);
      cyc();
      for (int k = 1; k <= 8; k++) begin
        push("per0_cnt", SEL_CNT, 16'd0);
        push("per0_irq", SEL_IRQ, 16'd0);
        push("per0_busy", SEL_BUSY, 16'd1);
        cyc();
      end
      go_idle(pol[0]);
    end

    // Mid-period duty change and set/clear race on the wrap edge.
    drive(16'h0F, 16'd4, 16'd1, 16'd1);
    for (int k = 0; k <= 10; k++) begin
      if (k == 2) bus.i_dc = 16'd3;
      bus.i_irq_clr = (k == 6) || (k == 8);
      if (k == 0) begin
        push("upd_e0_busy", SEL_BUSY, 16'd1);
        push("upd_e0_cnt", SEL_CNT, 16'd0);
      end else begin
        dcv  = (k >= 5) ? 3 : 1;
        irqv = (k >= 8) ? 1 : (k >= 6) ? 0 : (k >= 4) ? 1 : 0;
        push("upd_cnt", SEL_CNT, 16'(k % 4));
        push("upd_pwm", SEL_PWM, 16'(((k - 1) % 4) < dcv));
        push("upd_irq", SEL_IRQ, 16'(irqv));
      end
      cyc();
    end
    bus.i_irq_clr = 1'b0;
    go_idle(1'b0);
    push("upd_irq_kept", SEL_IRQ, 16'd1);
    compare_all();
    bus.i_irq_clr = 1'b1;
    push("upd_irq_clr", SEL_IRQ, 16'd0);
    cyc();
    bus.i_irq_clr = 1'b0;

    // Asynchronous reset during a high phase, then restart with EN still high.
    drive(16'h0F, 16'd4, 16'd1, 16'd2);
    for (int k = 0; k <= 5; k++) begin
      if (k == 5) begin
        push("rr_pre_pwm", SEL_PWM, 16'd1);
        push("rr_pre_irq", SEL_IRQ, 16'd1);
        push("rr_pre_cnt", SEL_CNT, 16'd1);
        push("rr_pre_busy", SEL_BUSY, 16'd1);
      end
      cyc();
    end
    #2 rst = 1'b1;
    #1;
    push("rr_pwm", SEL_PWM, 16'd0);
    push("rr_irq", SEL_IRQ, 16'd0);
    push("rr_cnt", SEL_CNT, 16'd0);
    push("rr_busy", SEL_BUSY, 16'd0);
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    push("rr_e0_busy", SEL_BUSY, 16'd1);
    push("rr_e0_cnt", SEL_CNT, 16'd0);
    push("rr_e0_irq", SEL_IRQ, 16'd0);
    cyc();
    for (int k = 1; k <= 4; k++) begin
      push("rr_cnt_run", SEL_CNT, 16'(k % 4));
      push("rr_pwm_run", SEL_PWM, 16'(((k - 1) % 4) < 2));
      cyc();
    end
    go_idle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
